// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: debounce FSM state
// encoding, default timing constants and the Moore output decode.
package button_conditioner_pkg;

  localparam int unsigned DB_CYCLES_DEF  = 1000000;
  localparam int unsigned REP_CYCLES_DEF = 25000000;
  localparam int unsigned CNT_W_DEF      = 25;
  localparam int unsigned NUM_BTN        = 4;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    HELD    = 3'd3,
    MCEN_ST = 3'd4,
    WFR     = 3'd5
  } btn_state_t;

  // Output bits for a state, ordered {dpb, scen, mcen}.
  function automatic logic [2:0] moore_out(btn_state_t s);
    case (s)
      SCEN_ST: return 3'b111;
      HELD:    return 3'b100;
      MCEN_ST: return 3'b101;
      WFR:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/btn_db_fsm.sv
// One pushbutton lane: 2-flop synchronizer, debounce/auto-repeat FSM and its
// shared qualification/repeat counter.
module btn_db_fsm
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
  parameter int unsigned REP_CYCLES = REP_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic btn_raw,
  output logic dpb,
  output logic scen,
  output logic mcen
);

  localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Outputs are reloaded only on a state change, so they always equal the
  // decode of the registered state.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state              <= INIT;
      cnt                <= '0;
      {dpb, scen, mcen}  <= 3'b000;
    end else begin
      case (state)
        INIT: begin
          cnt <= '0;
          if (sync) begin
            state             <= WQ;
            {dpb, scen, mcen} <= moore_out(WQ);
          end
        end
        WQ: begin
          if (!sync) begin
            state             <= INIT;
            cnt               <= '0;
            {dpb, scen, mcen} <= moore_out(INIT);
          end else if (cnt == DB_TERM) begin
            state             <= SCEN_ST;
            cnt               <= '0;
            {dpb, scen, mcen} <= moore_out(SCEN_ST);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SCEN_ST: begin
          state             <= HELD;
          cnt               <= '0;
          {dpb, scen, mcen} <= moore_out(HELD);
        end
        HELD: begin
          if (!sync) begin
            state             <= WFR;
            cnt               <= '0;
            {dpb, scen, mcen} <= moore_out(WFR);
          end else if (cnt == REP_TERM) begin
            state             <= MCEN_ST;
            cnt               <= '0;
            {dpb, scen, mcen} <= moore_out(MCEN_ST);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        MCEN_ST: begin
          state             <= HELD;
          cnt               <= '0;
          {dpb, scen, mcen} <= moore_out(HELD);
        end
        WFR: begin
          // A high sample resumes the hold with fresh repeat timing, no new press.
          if (sync) begin
            state             <= HELD;
            cnt               <= '0;
            {dpb, scen, mcen} <= moore_out(HELD);
          end else if (cnt == DB_TERM) begin
            state             <= INIT;
            cnt               <= '0;
            {dpb, scen, mcen} <= moore_out(INIT);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state             <= INIT;
          cnt               <= '0;
          {dpb, scen, mcen} <= moore_out(INIT);
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: independent debounce lanes producing level,
// single-press enable and auto-repeat enable per button.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
  parameter int unsigned REP_CYCLES = REP_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_dpb,
  output logic [3:0] btn_scen,
  output logic [3:0] btn_mcen
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_db_fsm #(
      .DB_CYCLES  (DB_CYCLES),
      .REP_CYCLES (REP_CYCLES),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .ClkPort (ClkPort),
      .Reset   (Reset),
      .btn_raw (btn_raw[i]),
      .dpb     (btn_dpb[i]),
      .scen    (btn_scen[i]),
      .mcen    (btn_mcen[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: timestamp-based reference model feeding a
// scoreboard queue, plus directed timing checks and random bouncing input.
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int REP = 10;

  logic       ClkPort;
  logic       Reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_dpb, btn_scen, btn_mcen;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] dpb;
    logic [3:0] scen;
    logic [3:0] mcen;
  } exp_t;

  exp_t exp_q[$];

  typedef enum int {M_IDLE, M_PULSE, M_HOLD, M_REL} mmode_t;

  button_conditioner #(
    .DB_CYCLES  (DB),
    .REP_CYCLES (REP),
    .CNT_W      (25)
  ) dut (
    .ClkPort  (ClkPort),
    .Reset    (Reset),
    .btn_raw  (btn_raw),
    .btn_dpb  (btn_dpb),
    .btn_scen (btn_scen),
    .btn_mcen (btn_mcen)
  );

  initial ClkPort = 1'b0;
  always #5 ClkPort = ~ClkPort;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, want);
    end
  endtask

  // Reference model: qualification and repeat are tracked as absolute edge
  // timestamps; the synchronizer is a two-sample delay.
  initial begin : model
    mmode_t     mode[4];
    logic       is_press[4];
    longint     run_start[4], held_start[4], low_start[4];
    longint     e_n;
    logic [3:0] d1, d2;
    logic       s;
    exp_t       e;
    e_n = 0;
    d1 = '0;
    d2 = '0;
    for (int b = 0; b < 4; b++) begin
      mode[b] = M_IDLE; is_press[b] = 1'b0;
      run_start[b] = -1; held_start[b] = 0; low_start[b] = 0;
    end
    forever begin
      @(posedge ClkPort);
      e = '0;
      if (Reset) begin
        d1 = '0;
        d2 = '0;
        for (int b = 0; b < 4; b++) begin
          mode[b] = M_IDLE;
          run_start[b] = -1;
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          s = d2[b];
          case (mode[b])
            M_IDLE: begin
              if (!s) run_start[b] = -1;
              else if (run_start[b] < 0) run_start[b] = e_n;
              else if (e_n - run_start[b] == DB) begin
                mode[b] = M_PULSE; is_press[b] = 1'b1;
              end
            end
            M_PULSE: begin
              mode[b] = M_HOLD; held_start[b] = e_n;
            end
            M_HOLD: begin
              if (!s) begin
                mode[b] = M_REL; low_start[b] = e_n;
              end else if (e_n - held_start[b] == REP) begin
                mode[b] = M_PULSE; is_press[b] = 1'b0;
              end
            end
            default: begin
              if (s) begin
                mode[b] = M_HOLD; held_start[b] = e_n;
              end else if (e_n - low_start[b] == DB) begin
                mode[b] = M_IDLE; run_start[b] = -1;
              end
            end
          endcase
        end
        d2 = d1;
        d1 = btn_raw;
        for (int b = 0; b < 4; b++) begin
          e.dpb[b]  = (mode[b] != M_IDLE);
          e.mcen[b] = (mode[b] == M_PULSE);
          e.scen[b] = (mode[b] == M_PULSE) && is_press[b];
        end
      end
      exp_q.push_back(e);
      e_n++;
    end
  end

  // Monitor: outputs are presented every cycle; compare against the model.
  initial begin : monitor
    exp_t w;
    forever begin
      @(negedge ClkPort);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got=no_expectation expected=one_entry", $time);
      end else begin
        w = exp_q.pop_front();
        check("sb_dpb", btn_dpb, w.dpb);
        check("sb_scen", btn_scen, w.scen);
        check("sb_mcen", btn_mcen, w.mcen);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge ClkPort);
  endtask

  task automatic do_reset(input int n);
    #2 Reset = 1'b1;
    #1;
    check("reset_dpb", btn_dpb, 4'b0000);
    check("reset_scen", btn_scen, 4'b0000);
    check("reset_mcen", btn_mcen, 4'b0000);
    repeat (n) @(negedge ClkPort);
    #2 Reset = 1'b0;
  endtask

  initial begin : stim
    int         bounce_pat[7];
    int         hold_left[4];
    logic [3:0] w4;
    bounce_pat = '{1, 1, 0, 1, 1, 1, 1};
    Reset   = 1'b1;
    btn_raw = 4'b0000;
    repeat (3) @(negedge ClkPort);
    check("init_dpb", btn_dpb, 4'b0000);
    check("init_scen", btn_scen, 4'b0000);
    #2 Reset = 1'b0;
    idle(6);

    // Clean press on bit 3: enables for one cycle after edge 6.
    btn_raw = 4'b1000;
    for (int k = 0; k <= 8; k++) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
      w4 = (k == 6) ? 4'b1000 : 4'b0000;
      check("clean_scen", btn_scen, w4);
      check("clean_mcen", btn_mcen, w4);
      w4 = (k >= 6) ? 4'b1000 : 4'b0000;
      check("clean_dpb", btn_dpb, w4);
    end
    btn_raw = 4'b0000;
    idle(12);

    // Bouncy press on bit 2: qualification restarts, single pulse at edge 9.
    btn_raw[2] = 1'(bounce_pat[0]);
    for (int k = 0; k <= 14; k++) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
      w4 = (k == 9) ? 4'b0100 : 4'b0000;
      check("bounce_scen", btn_scen, w4);
      btn_raw[2] = (k + 1 < 7) ? 1'(bounce_pat[k + 1]) : 1'b1;
    end
    btn_raw = 4'b0000;
    idle(12);

    // Auto-repeat on bit 1.
    btn_raw = 4'b0010;
    for (int k = 0; k <= 37; k++) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
      w4 = (k == 6 || k == 17 || k == 28) ? 4'b0010 : 4'b0000;
      check("repeat_mcen", btn_mcen, w4);
      w4 = (k == 6) ? 4'b0010 : 4'b0000;
      check("repeat_scen", btn_scen, w4);
    end
    btn_raw = 4'b0000;
    idle(12);

    // Release glitch on bit 0, then stable release.
    btn_raw = 4'b0001;
    repeat (8) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
    end
    btn_raw = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
      btn_raw = 4'b0001;
      check("glitch_dpb", btn_dpb, 4'b0001);
      check("glitch_scen", btn_scen, 4'b0000);
    end
    btn_raw = 4'b0000;
    for (int k = 0; k <= 8; k++) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
      w4 = (k < 6) ? 4'b0001 : 4'b0000;
      check("release_dpb", btn_dpb, w4);
      check("release_scen", btn_scen, 4'b0000);
    end
    idle(4);

    // Reset while bit 0 is held, then requalify after release of Reset.
    btn_raw = 4'b0001;
    idle(12);
    do_reset(2);
    for (int k = 0; k <= 12; k++) begin
      @(posedge ClkPort);
      @(negedge ClkPort);
      w4 = (k == 6) ? 4'b0001 : 4'b0000;
      check("rst_hold_scen", btn_scen, w4);
    end
    btn_raw = 4'b0000;
    idle(12);

    // Random bouncing input with occasional resets.
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ClkPort);
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          btn_raw[b]   = 1'($urandom_range(0, 1));
          hold_left[b] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2))
                                                    : int'($urandom_range(3, 30));
        end else begin
          hold_left[b]--;
        end
      end
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
    end
    btn_raw = 4'b0000;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000: number of consecutive stable synchronized samples (10 ms at 100 MHz) that qualify a press or a release.
REQ-002 The block SHALL have parameter REP_CYCLES, default 25000000: number of hold cycles between auto-repeat pulses (250 ms at 100 MHz).
REQ-003 The block SHALL have parameter CNT_W, default 25: counter width; values of DB_CYCLES or REP_CYCLES that do not fit in 2^CNT_W are illegal.
REQ-004 The block SHALL have port ClkPort, input, 1 bit: system clock, rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port btn_raw, input, 4 bits: raw pushbuttons; [3] BtnU, [2] BtnD, [1] BtnL, [0] BtnR; active-high; asynchronous to ClkPort.
REQ-007 The block SHALL have port btn_dpb, output, 4 bits: debounced button level.
REQ-008 The block SHALL have port btn_scen, output, 4 bits: single-clock enable, one pulse per qualified press.
REQ-009 The block SHALL have port btn_mcen, output, 4 bits: multi-clock enable, one pulse on press plus one pulse per REP_CYCLES of continued hold.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the second flop (sync).
REQ-011 Each of the 4 bits SHALL be handled by an independent, identical FSM and counter (cnt); there SHALL be no interaction between bits.
REQ-012 The FSM states SHALL be INIT, WQ (wait quiet), SCEN_ST, HELD, MCEN_ST and WFR (wait for release quiet).
REQ-013 INIT: cnt is 0; if sync=1, the FSM SHALL go to WQ with cnt=0; otherwise it SHALL stay in INIT.
REQ-014 WQ: if sync=0, the FSM SHALL go to INIT; else if cnt=DB_CYCLES-1, it SHALL go to SCEN_ST with cnt=0; otherwise cnt SHALL increment.
REQ-015 SCEN_ST: the FSM SHALL remain here exactly 1 cycle, then go to HELD with cnt=0.
REQ-016 HELD: if sync=0, the FSM SHALL go to WFR with cnt=0; else if cnt=REP_CYCLES-1, it SHALL go to MCEN_ST with cnt=0; otherwise cnt SHALL increment.
REQ-017 MCEN_ST: the FSM SHALL remain here exactly 1 cycle, then go to HELD with cnt=0.
REQ-018 WFR: if sync=1, the FSM SHALL go to HELD with cnt=0, so that a bounce or short release neither generates a new SCEN nor continues the repeat timing; else if cnt=DB_CYCLES-1, it SHALL go to INIT; otherwise cnt SHALL increment.
REQ-019 Outputs SHALL be Moore outputs decoded from the registered state: dpb=1 in SCEN_ST, HELD, MCEN_ST and WFR; scen=1 only in SCEN_ST; mcen=1 in SCEN_ST and MCEN_ST; otherwise all are 0.
REQ-020 Press latency: taking edge 0 as the first ClkPort edge that samples btn_raw high, with the input held stable, SCEN_ST SHALL be entered at edge DB_CYCLES+2.
REQ-021 Release latency: taking edge 0 as the first edge that samples btn_raw low while in HELD, with the input held stable, dpb SHALL fall at edge DB_CYCLES+2.
REQ-022 Any low sync sample during WQ SHALL restart qualification from INIT; there SHALL be no partial credit.
REQ-023 cnt SHALL never exceed its terminal value and SHALL never wrap.
REQ-024 scen and mcen SHALL never be high for 2 consecutive cycles on the same bit.

Reset
REQ-025 While Reset=1, all synchronizer flops, counters and outputs SHALL be 0 and all FSMs SHALL be in INIT, independent of ClkPort.
REQ-026 After Reset is deasserted during a hold, a still-held button SHALL requalify through WQ and produce exactly one SCEN pulse.
REQ-027 Reset SHALL be released synchronously with ClkPort by the top level; the block itself SHALL not re-synchronize it.

Structure
REQ-028 A shared package SHALL hold the state encoding (3 bits, 6 states) and the default DB_CYCLES, REP_CYCLES and CNT_W constants.
REQ-029 The top SHALL contain one sub-module, btn_db_fsm (1-bit synchronizer, FSM and counter), instantiated 4 times via generate.
REQ-030 btn_scen SHALL drive the block_controller movement inputs, and btn_mcen SHALL be available for held-button cursor stepping.

Verification (DB_CYCLES=4, REP_CYCLES=10)
REQ-031 Clean press: btn_raw[3] rises at edge 0 and is held -> btn_scen[3] and btn_mcen[3] are high in the cycle starting at edge 6; btn_dpb[3] rises at edge 6; other bits stay 0.
REQ-032 Bounce: btn_raw[2] reads 1,1,0,1,1,1,1 on edges 0-6 -> no scen before edge 9; exactly one scen pulse, starting at edge 9.
REQ-033 Auto-repeat: btn_raw[1] held for 40 cycles -> mcen pulses at edges 6, 17 and 28; scen only at edge 6.
REQ-034 Release glitch: while in HELD, one low sample, then high -> dpb stays 1 and no new scen; after a stable low, dpb falls at edge DB_CYCLES+2=6 measured from the first low sample.
REQ-035 Reset mid-hold: assert Reset while btn_raw[0] is held in HELD -> all outputs 0 immediately; after deassertion with the button still held -> one scen at edge 6 after release.
